timing_check_monitor: RTL and testbench

Synthesizable, cycle-based monitor that performs `$setup`/`$hold`-style checks on two signals in hardware. It oversamples a reference strobe and a data signal on the system clock and measures edge-to-edge distances in clock cycles. It reports each violation as a kind/delta event over a valid/ready handshake, keeps saturating per-kind counts and toggles a notifier bit. It sits downstream of the specify-block timing checks and consumes the same check semantics (reference event, data event, limit, notifier) for on-chip or emulation use.

---
 rtl/timing_check_pkg.sv | 30 +++
 rtl/sync_edge_det.sv | 57 +++++
 rtl/timing_check_monitor.sv | 197 +++++++++++++++++++
 tb/tb_timing_check_monitor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timing_check_pkg
//  Description : Shared types for the cycle-based setup/hold timing monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package timing_check_pkg;

    // Event delta is carried at a fixed width and trimmed to CNT_W at the port.
    localparam int C_DELTA_W = 32;

    typedef enum logic [1:0] {
        VIOL_NONE  = 2'b00,
        VIOL_SETUP = 2'b01,
        VIOL_HOLD  = 2'b10
    } viol_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRACK    = 2'd1,
        ST_HOLD_WIN = 2'd2
    } fsm_state_t;

    typedef struct packed {
        viol_kind_t             kind;
        logic [C_DELTA_W-1:0]   delta;
    } viol_event_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Optional synchronizer chain followed by a registered edge
//                detector producing rise / fall / any-edge strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic w_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_sync = sig_in;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] r_chain;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], sig_in};
                end
            end
            assign w_sync = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_rise <= w_sync & ~r_prev;
            r_fall <= ~w_sync & r_prev;
        end
    end

    assign rise     = r_rise;
    assign fall     = r_fall;
    assign any_edge = r_rise | r_fall;

endmodule
`default_nettype wire

// File: rtl/timing_check_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : timing_check_monitor
//  Description : Hardware setup/hold checker; reports violations as kind/delta
//                events over valid/ready with saturating per-kind statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module timing_check_monitor
    import timing_check_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int SETUP_CYC   = 4,
    parameter int HOLD_CYC    = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              ref_in,
    input  logic              data_in,
    output logic              viol_valid,
    input  logic              viol_ready,
    output logic [1:0]        viol_kind,
    output logic [CNT_W-1:0]  viol_delta,
    output logic              viol_overflow,
    output logic              notifier,
    output logic [STAT_W-1:0] setup_count,
    output logic [STAT_W-1:0] hold_count,
    input  logic              clr_stats
);

    localparam logic [CNT_W-1:0] c_setup_lim = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] c_hold_lim  = CNT_W'(HOLD_CYC);
    localparam bit               c_hold_en   = (HOLD_CYC > 0);

    logic w_ref_edge, w_ref_fall_unused, w_ref_any_unused;
    logic w_data_edge, w_data_rise_unused, w_data_fall_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ref_det (
        .clk(clk), .rst_n(rst_n), .sig_in(ref_in),
        .rise(w_ref_edge), .fall(w_ref_fall_unused), .any_edge(w_ref_any_unused)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_data_det (
        .clk(clk), .rst_n(rst_n), .sig_in(data_in),
        .rise(w_data_rise_unused), .fall(w_data_fall_unused), .any_edge(w_data_edge)
    );

    // Distance since the last data edge; zero in the edge cycle itself.
    logic [CNT_W-1:0] r_since_data;
    logic [CNT_W-1:0] w_since_data;
    assign w_since_data = w_data_edge ? '0 : r_since_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_since_data <= '1;
        end else if (w_since_data != '1) begin
            r_since_data <= w_since_data + 1'b1;
        end else begin
            r_since_data <= w_since_data;
        end
    end

    fsm_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt;
    logic             w_checking, w_window;

    assign w_hold_cnt = r_hold_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_checking && w_ref_edge) begin
                r_hold_cnt <= '0;
            end else if (w_window) begin
                r_hold_cnt <= w_hold_cnt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nxt = ST_TRACK;
                ST_TRACK:    if (w_ref_edge && c_hold_en) w_state_nxt = ST_HOLD_WIN;
                ST_HOLD_WIN: if (!w_ref_edge && w_hold_cnt == c_hold_lim) w_state_nxt = ST_TRACK;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_checking = 1'b0;
        w_window   = 1'b0;
        case (r_state)
            ST_TRACK:    w_checking = 1'b1;
            ST_HOLD_WIN: begin
                w_checking = 1'b1;
                w_window   = 1'b1;
            end
            default: ;
        endcase
    end

    // A coincident ref edge always wins as a zero-distance setup violation.
    viol_event_t w_evt;
    logic        w_viol;

    always_comb begin
        w_evt = '0;
        if (w_checking && w_ref_edge && w_since_data < c_setup_lim) begin
            w_evt.kind  = VIOL_SETUP;
            w_evt.delta = C_DELTA_W'(w_since_data);
        end else if (w_window && w_data_edge && !w_ref_edge &&
                     w_hold_cnt != '0 && w_hold_cnt <= c_hold_lim) begin
            w_evt.kind  = VIOL_HOLD;
            w_evt.delta = C_DELTA_W'(w_hold_cnt);
        end
    end

    assign w_viol = (w_evt.kind != VIOL_NONE);

    generate
        if (C_DELTA_W > CNT_W) begin : g_delta_sink
            logic w_delta_unused;
            assign w_delta_unused = ^w_evt.delta[C_DELTA_W-1:CNT_W];
        end
    endgenerate

    logic              r_valid, r_overflow, r_notifier;
    viol_kind_t        r_kind;
    logic [CNT_W-1:0]  r_delta;
    logic [STAT_W-1:0] r_setup_count, r_hold_count;
    logic              w_pop;

    assign w_pop = r_valid && viol_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_kind        <= VIOL_NONE;
            r_delta       <= '0;
            r_overflow    <= 1'b0;
            r_notifier    <= 1'b0;
            r_setup_count <= '0;
            r_hold_count  <= '0;
        end else begin
            if (w_viol && (!r_valid || w_pop)) begin
                r_valid <= 1'b1;
                r_kind  <= w_evt.kind;
                r_delta <= w_evt.delta[CNT_W-1:0];
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end

            if (clr_stats) begin
                r_overflow <= 1'b0;
            end else if (w_viol && r_valid && !w_pop) begin
                r_overflow <= 1'b1;
            end

            if (w_viol) begin
                r_notifier <= ~r_notifier;
            end

            if (clr_stats) begin
                r_setup_count <= '0;
                r_hold_count  <= '0;
            end else if (w_viol) begin
                if (w_evt.kind == VIOL_SETUP && r_setup_count != '1) begin
                    r_setup_count <= r_setup_count + 1'b1;
                end
                if (w_evt.kind == VIOL_HOLD && r_hold_count != '1) begin
                    r_hold_count <= r_hold_count + 1'b1;
                end
            end
        end
    end

    assign viol_valid    = r_valid;
    assign viol_kind     = r_kind;
    assign viol_delta    = r_delta;
    assign viol_overflow = r_overflow;
    assign notifier      = r_notifier;
    assign setup_count   = r_setup_count;
    assign hold_count    = r_hold_count;

endmodule
`default_nettype wire

// File: tb/tb_timing_check_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timing_check_monitor
//  Description : Directed and randomized bench for timing_check_monitor with a
//                pin-history reference model of the setup/hold rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timing_check_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int SETUP_CYC   = 4;
    localparam int HOLD_CYC    = 2;
    localparam int STAT_W      = 16;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int HIST        = 8192;
    localparam int NEG         = -100000;
    localparam int STAT_MAX    = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n, enable, ref_in, data_in, viol_ready, clr_stats;
    logic              viol_valid, viol_overflow, notifier;
    logic [1:0]        viol_kind;
    logic [CNT_W-1:0]  viol_delta;
    logic [STAT_W-1:0] setup_count, hold_count;

    always #5 clk = ~clk;

    timing_check_monitor #(
        .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .SETUP_CYC(SETUP_CYC),
        .HOLD_CYC(HOLD_CYC), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ref_in(ref_in), .data_in(data_in),
        .viol_valid(viol_valid), .viol_ready(viol_ready), .viol_kind(viol_kind),
        .viol_delta(viol_delta), .viol_overflow(viol_overflow), .notifier(notifier),
        .setup_count(setup_count), .hold_count(hold_count), .clr_stats(clr_stats)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pin samples indexed by clock edge, plus the model's observable state.
    bit d_h [HIST];
    bit r_h [HIST];
    int cyc = 0;
    int valid_from = 1;
    int last_d = NEG;
    int last_r = NEG;
    bit armed = 1'b0;
    bit m_valid = 1'b0, m_ovf = 1'b0, m_notif = 1'b0;
    int m_kind = 0, m_delta = 0, m_scnt = 0, m_hcnt = 0;
    bit cur_d = 1'b0, cur_r = 1'b0;
    int acc_q [$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        d_h[cyc]   = 1'b0;
        r_h[cyc]   = 1'b0;
        valid_from = cyc + 1;
        last_d     = NEG;
        last_r     = NEG;
        m_valid    = 1'b0;
        m_ovf      = 1'b0;
        m_notif    = 1'b0;
        m_scnt     = 0;
        m_hcnt     = 0;
    endtask

    task automatic model_edge(input bit rdy, input bit clr);
        int  n;
        bit  de, re, viol, pop;
        int  kind, delta;
        n     = cyc - LAT;
        viol  = 1'b0;
        kind  = 0;
        delta = 0;
        if (n >= valid_from && n >= 1) begin
            de = (d_h[n] != d_h[n-1]);
            re = r_h[n] && !r_h[n-1];
            if (de) last_d = n;
            if (armed && re && (n - last_d) < SETUP_CYC) begin
                viol = 1'b1; kind = 1; delta = n - last_d;
            end else if (armed && de && !re && (n - last_r) >= 1 && (n - last_r) <= HOLD_CYC) begin
                viol = 1'b1; kind = 2; delta = n - last_r;
            end
            if (re) last_r = n;
        end
        pop = m_valid && rdy;
        if (viol) begin
            if (!m_valid || pop) begin
                m_valid = 1'b1; m_kind = kind; m_delta = delta;
            end else if (!clr) begin
                m_ovf = 1'b1;
            end
            m_notif = ~m_notif;
        end else if (pop) begin
            m_valid = 1'b0;
        end
        if (clr) begin
            m_scnt = 0; m_hcnt = 0; m_ovf = 1'b0;
        end else if (viol) begin
            if (kind == 1 && m_scnt < STAT_MAX) m_scnt++;
            if (kind == 2 && m_hcnt < STAT_MAX) m_hcnt++;
        end
    endtask

    task automatic compare_outputs();
        check_val("viol_valid", 64'(viol_valid), 64'(m_valid));
        if (m_valid) begin
            check_val("viol_kind", 64'(viol_kind), 64'(m_kind));
            check_val("viol_delta", 64'(viol_delta), 64'(m_delta));
        end
        check_val("notifier", 64'(notifier), 64'(m_notif));
        check_val("viol_overflow", 64'(viol_overflow), 64'(m_ovf));
        check_val("setup_count", 64'(setup_count), 64'(m_scnt));
        check_val("hold_count", 64'(hold_count), 64'(m_hcnt));
    endtask

    task automatic step(input bit d, input bit r, input bit rdy, input bit clr, input bit rst);
        data_in    = d;
        ref_in     = r;
        viol_ready = rdy;
        clr_stats  = clr;
        rst_n      = ~rst;
        cur_d      = d;
        cur_r      = r;
        if (viol_valid === 1'b1 && rdy && !rst) begin
            acc_q.push_back(int'(viol_kind) * 1000 + int'(viol_delta));
        end
        @(posedge clk);
        cyc++;
        d_h[cyc] = d;
        r_h[cyc] = r;
        if (rst) model_reset();
        else     model_edge(rdy, clr);
        #1;
        compare_outputs();
    endtask

    task automatic tick(input bit rdy);
        step(cur_d, cur_r, rdy, 1'b0, 1'b0);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int k = 0;
        while (viol_valid !== 1'b1 && k < max_cyc) begin
            tick(1'b0);
            k++;
        end
        check_val({tag, "_arrives"}, 64'(viol_valid), 64'(1));
    endtask

    task automatic check_acc(input string tag, input int idx, input int exp);
        check_val(tag, 64'(acc_q.size() > idx ? acc_q[idx] : -1), 64'(exp));
    endtask

    initial begin
        enable = 1'b0; data_in = 1'b0; ref_in = 1'b0;
        viol_ready = 1'b0; clr_stats = 1'b0; rst_n = 1'b0;
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rst_valid",    64'(viol_valid),    64'(0));
        check_val("rst_kind",     64'(viol_kind),     64'(0));
        check_val("rst_delta",    64'(viol_delta),    64'(0));
        check_val("rst_overflow", 64'(viol_overflow), 64'(0));
        check_val("rst_notifier", 64'(notifier),      64'(0));
        check_val("rst_setup",    64'(setup_count),   64'(0));
        check_val("rst_hold",     64'(hold_count),    64'(0));

        enable = 1'b1;
        repeat (8) tick(1'b1);
        armed = 1'b1;

        // Data toggles, ref rises two cycles later.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_valid("setup", 10);
        check_val("setup_kind",  64'(viol_kind),   64'(1));
        check_val("setup_delta", 64'(viol_delta),  64'(2));
        check_val("setup_notif", 64'(notifier),    64'(1));
        check_val("setup_cnt",   64'(setup_count), 64'(1));
        tick(1'b1);
        repeat (6) step(cur_d, 1'b0, 1'b1, 1'b0, 1'b0);

        // Hold window: toggles at +1 and +2 violate, +3 is clean.
        acc_q.delete();
        step(cur_d, 1'b1, 1'b1, 1'b0, 1'b0);
        step(~cur_d, 1'b1, 1'b1, 1'b0, 1'b0);
        step(~cur_d, 1'b1, 1'b1, 1'b0, 1'b0);
        step(~cur_d, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8) tick(1'b1);
        check_val("hold_events", 64'(acc_q.size()), 64'(2));
        check_acc("hold_ev0", 0, 2001);
        check_acc("hold_ev1", 1, 2002);
        check_val("hold_cnt", 64'(hold_count), 64'(2));

        // Coincident data and ref edges.
        repeat (6) step(cur_d, 1'b0, 1'b1, 1'b0, 1'b0);
        acc_q.delete();
        step(~cur_d, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8) tick(1'b1);
        check_val("simul_events", 64'(acc_q.size()), 64'(1));
        check_acc("simul_ev0", 0, 1000);
        check_val("simul_hold", 64'(hold_count), 64'(2));

        // Backpressure: two setup violations while the consumer stalls.
        step(cur_d, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5) step(cur_d, 1'b0, 1'b1, 1'b0, 1'b0);
        step(~cur_d, 1'b1, 1'b0, 1'b0, 1'b0);
        step(cur_d, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        tick(1'b0);
        step(~cur_d, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b0);
        check_val("ovf_valid", 64'(viol_valid),    64'(1));
        check_val("ovf_kind",  64'(viol_kind),     64'(1));
        check_val("ovf_delta", 64'(viol_delta),    64'(0));
        check_val("ovf_flag",  64'(viol_overflow), 64'(1));
        check_val("ovf_setup", 64'(setup_count),   64'(2));
        check_val("ovf_notif", 64'(notifier),      64'(0));
        step(cur_d, cur_r, 1'b0, 1'b1, 1'b0);
        check_val("clr_setup",    64'(setup_count),   64'(0));
        check_val("clr_hold",     64'(hold_count),    64'(0));
        check_val("clr_overflow", 64'(viol_overflow), 64'(0));
        check_val("clr_keeps_ev", 64'(viol_valid),    64'(1));
        tick(1'b1);
        tick(1'b1);

        // Reset while a hold event is pending and a new window is open.
        repeat (6) step(cur_d, 1'b0, 1'b1, 1'b0, 1'b0);
        step(cur_d, 1'b1, 1'b0, 1'b0, 1'b0);
        step(~cur_d, 1'b1, 1'b0, 1'b0, 1'b0);
        step(cur_d, 1'b0, 1'b0, 1'b0, 1'b0);
        step(cur_d, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0);
        check_val("pre_rst_valid", 64'(viol_valid), 64'(1));
        enable = 1'b0;
        armed  = 1'b0;
        step(cur_d, cur_r, 1'b0, 1'b0, 1'b1);
        check_val("mrst_valid",    64'(viol_valid),    64'(0));
        check_val("mrst_kind",     64'(viol_kind),     64'(0));
        check_val("mrst_delta",    64'(viol_delta),    64'(0));
        check_val("mrst_overflow", 64'(viol_overflow), 64'(0));
        check_val("mrst_notifier", 64'(notifier),      64'(0));
        check_val("mrst_setup",    64'(setup_count),   64'(0));
        check_val("mrst_hold",     64'(hold_count),    64'(0));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(1'b1);
        check_val("disabled_quiet", 64'(viol_valid), 64'(0));
        enable = 1'b1;
        repeat (8) step(cur_d, 1'b0, 1'b1, 1'b0, 1'b0);
        armed = 1'b1;
        step(~cur_d, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1);
        step(cur_d, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_valid("rearm", 10);
        check_val("rearm_kind",  64'(viol_kind),  64'(1));
        check_val("rearm_delta", 64'(viol_delta), 64'(2));
        tick(1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            bit d, r, rdy, clr;
            d   = ($urandom_range(0, 3) == 0) ? ~cur_d : cur_d;
            r   = ($urandom_range(0, 4) == 0) ? ~cur_r : cur_r;
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) == 0);
            step(d, r, rdy, clr, 1'b0);
        end
        repeat (8) tick(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
